ysyx_24110026_seq_ctrl: RTL and testbench
=========================================

Name: ysyx_24110026_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32E core; it orders fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives valid/ready handshakes to the instruction-fetch port and the load/store port, and gates PC and register-file write enables.
- Owns a watchdog on both memory waits and a retired-instruction counter.
- Sits in ysyx_24110026_top between the PC register, the decoder and the ALU/LSU datapath.

Parameters:
- TIMEOUT, 16: maximum cycles spent in IWAIT or MWAIT before raising err; must be ≥2.
- CNT_W, 32: width of inst_cnt.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid  out  1  fetch request, PC already driven by the PC register.
- ifu_req_ready  in  1  fetch port accepts the request.
- ifu_resp_valid  in  1  fetched instruction valid.
- ifu_resp_inst  in  32  fetched instruction word.
- inst_q  out  32  latched instruction feeding the decoder.
- dec_mem  in  1  decoded load or store.
- dec_rd_we  in  1  decoded instruction writes rd.
- dec_ebreak  in  1  decoded ebreak.
- dec_illegal  in  1  no valid decode.
- lsu_req_valid  out  1  load/store request.
- lsu_req_ready  in  1  LSU accepts the request.
- lsu_resp_valid  in  1  LSU completion; load data is valid.
- pc_we  out  1  one-cycle PC update strobe.
- rf_we  out  1  one-cycle register-file write strobe.
- halt  out  1  sticky; set by ebreak.
- err  out  1  sticky; set by illegal instruction or timeout.
- state  out  4  current FSM state, for debug and the bench.
- inst_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, inst_q=0, inst_cnt=0, halt=0, err=0, timeout counter=0.
  - All strobes and valids are 0.
  - Asserting reset in any state, including mid-handshake, aborts immediately; no pc_we or rf_we fires.
- States and transitions:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: ifu_req_valid=1. Stay while ifu_req_ready=0. On ready: if ifu_resp_valid=1 the same cycle, latch inst_q and go to DECODE; otherwise go to IWAIT.
  - IWAIT: ifu_req_valid=0. On ifu_resp_valid, latch inst_q and go to DECODE.
  - DECODE: one cycle for decoder settling. Priority: dec_illegal → ERR (err=1); else dec_ebreak → HALT (halt=1); else EXEC.
  - EXEC: one cycle for the ALU. dec_mem=1 → MEM; else WB.
  - MEM: lsu_req_valid=1 until lsu_req_ready. Same-cycle ready and resp go to WB; ready without resp goes to MWAIT.
  - MWAIT: on lsu_resp_valid, go to WB.
  - WB: pc_we=1; rf_we=dec_rd_we; inst_cnt+=1 (wraps modulo 2^CNT_W); next state FETCH.
  - HALT and ERR: terminal until reset. All valids and strobes are 0.
- Outputs are registered state decodes: valids and strobes are pure functions of state plus dec_rd_we.
- Valid stability: once ifu_req_valid or lsu_req_valid is asserted, it stays high until its ready is seen.
- Watchdog:
  - Counter clears on every entry to IWAIT or MWAIT and increments each cycle spent there.
  - When it reaches TIMEOUT-1 with no response, the next state is ERR with err=1.
  - A response arriving in that same cycle wins: go to DECODE or WB, err stays 0.
  - Not active in FETCH or MEM; ready stalls are unbounded.
- Responses outside IWAIT, MWAIT or the same-cycle case are ignored.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 5 cycles (adds MEM).

Decomposition:
- State encoding localparams (IDLE=0 … ERR=8) go in defines.v next to the opcode macros, shared with the bench.
- One sub-module: ysyx_24110026_wdog, the clearable watchdog counter. Inputs clr, en; output expire at TIMEOUT-1.

Test Plan:
- Reset, then ready and resp tied high, feeding 3 addi (dec_rd_we=1) → pc_we and rf_we pulse at cycles 5, 9, 13 after release; inst_cnt=3.
- lw with lsu_req_ready held 2 cycles and lsu_resp_valid 3 cycles after acceptance → states MEM,MEM,MWAIT×3,WB; single rf_we; sw (dec_rd_we=0) → pc_we=1, rf_we=0.
- ebreak (inst 0x00100073, dec_ebreak=1) → halt=1 the cycle after DECODE, state=HALT; no further ifu_req_valid for 50 cycles; inst_cnt unchanged.
- TIMEOUT=16, ifu_resp_valid never arrives → err=1 exactly 16 cycles after IWAIT entry; repeat with resp on the 16th cycle → DECODE, err=0.
- dec_illegal and dec_ebreak both 1 → ERR, err=1, halt=0.
- rst_n pulsed low for 1 cycle during MWAIT → all outputs at reset values asynchronously, no pc_we or rf_we; restarts at IDLE→FETCH.

Source files
------------

// File: rtl/ysyx_24110026_seq_ctrl_pkg.sv
// Shared state encoding and constants for the RV32E multi-cycle sequencer.
// The bench imports this too, so debug state values line up on both sides.
package ysyx_24110026_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_IWAIT  = 4'd2,
        ST_DECODE = 4'd3,
        ST_EXEC   = 4'd4,
        ST_MEM    = 4'd5,
        ST_MWAIT  = 4'd6,
        ST_WB     = 4'd7,
        ST_ERR    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Memory-wait states are the only ones guarded by the watchdog.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_IWAIT) || (s == ST_MWAIT);
    endfunction

endpackage

// File: rtl/ysyx_24110026_wdog.sv
// Clearable watchdog counter: runs while en, expires on its TIMEOUT-th cycle.
module ysyx_24110026_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = en && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_24110026_seq_ctrl.sv
// One-instruction-at-a-time sequencer: fetch, decode, execute, memory, writeback.
// Handshake valids and write strobes are pure decodes of the registered state.
module ysyx_24110026_seq_ctrl
    import ysyx_24110026_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_resp_valid,
    input  logic [31:0]      ifu_resp_inst,
    output logic [31:0]      inst_q,
    input  logic             dec_mem,
    input  logic             dec_rd_we,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_resp_valid,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halt,
    output logic             err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] inst_cnt
);

    state_e           r_state;
    state_e           w_nxt;
    logic             w_latch;
    logic             w_wait;
    logic             w_wdog_clr;
    logic             w_expire;
    logic [31:0]      r_inst;
    logic [CNT_W-1:0] r_cnt;
    logic             r_halt;
    logic             r_err;

    // Held clear outside the wait states, so every entry starts from zero.
    assign w_wait     = is_wait_state(r_state);
    assign w_wdog_clr = !w_wait;

    ysyx_24110026_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_wdog_clr),
        .en     (w_wait),
        .expire (w_expire)
    );

    always_comb begin
        w_nxt   = r_state;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE:   w_nxt = ST_FETCH;
            ST_FETCH: begin
                if (ifu_req_ready) begin
                    if (ifu_resp_valid) begin
                        w_nxt   = ST_DECODE;
                        w_latch = 1'b1;
                    end else begin
                        w_nxt = ST_IWAIT;
                    end
                end
            end
            // A response in the expiry cycle still wins over the timeout.
            ST_IWAIT: begin
                if (ifu_resp_valid) begin
                    w_nxt   = ST_DECODE;
                    w_latch = 1'b1;
                end else if (w_expire) begin
                    w_nxt = ST_ERR;
                end
            end
            ST_DECODE: begin
                if (dec_illegal)     w_nxt = ST_ERR;
                else if (dec_ebreak) w_nxt = ST_HALT;
                else                 w_nxt = ST_EXEC;
            end
            ST_EXEC:   w_nxt = dec_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (lsu_req_ready) w_nxt = lsu_resp_valid ? ST_WB : ST_MWAIT;
            end
            ST_MWAIT: begin
                if (lsu_resp_valid) w_nxt = ST_WB;
                else if (w_expire)  w_nxt = ST_ERR;
            end
            ST_WB:     w_nxt = ST_FETCH;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_inst  <= '0;
            r_cnt   <= '0;
            r_halt  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_latch)             r_inst <= ifu_resp_inst;
            if (r_state == ST_WB)    r_cnt  <= r_cnt + 1'b1;
            if (w_nxt == ST_HALT)    r_halt <= 1'b1;
            if (w_nxt == ST_ERR)     r_err  <= 1'b1;
        end
    end

    assign ifu_req_valid = (r_state == ST_FETCH);
    assign lsu_req_valid = (r_state == ST_MEM);
    assign pc_we         = (r_state == ST_WB);
    assign rf_we         = (r_state == ST_WB) && dec_rd_we;
    assign inst_q        = r_inst;
    assign inst_cnt      = r_cnt;
    assign halt          = r_halt;
    assign err           = r_err;
    assign state         = r_state;

endmodule

// File: tb/tb_ysyx_24110026_seq_ctrl.sv
// Bench for the sequencer: procedural instruction-lifecycle model compared every
// cycle, directed scenarios with literal expectations, then randomized episodes.
module tb_ysyx_24110026_seq_ctrl;
    import ysyx_24110026_seq_ctrl_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0]      ifu_resp_inst, inst_q;
    logic             dec_mem, dec_rd_we, dec_ebreak, dec_illegal;
    logic             lsu_req_valid, lsu_req_ready, lsu_resp_valid;
    logic             pc_we, rf_we, halt, err;
    logic [3:0]       state;
    logic [CNT_W-1:0] inst_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24110026_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
        .inst_q(inst_q),
        .dec_mem(dec_mem), .dec_rd_we(dec_rd_we), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
        .pc_we(pc_we), .rf_we(rf_we), .halt(halt), .err(err),
        .state(state), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    state_e           e_st   = ST_IDLE;
    logic [31:0]      e_inst = '0;
    logic [CNT_W-1:0] e_cnt  = '0;
    logic             e_halt = 1'b0;
    logic             e_err  = 1'b0;
    bit               m_abort = 1'b0;

    task automatic m_tick();
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_abort = 1'b1;
    endtask

    task automatic terminal();
        while (!m_abort) m_tick();
    endtask

    // Waits for a response with at most TIMEOUT cycles of patience.
    task automatic wait_resp(input bit is_ifu, output bit ok);
        int n = 0;
        ok = 1'b0;
        forever begin
            m_tick();
            if (m_abort) return;
            if (is_ifu ? ifu_resp_valid : lsu_resp_valid) begin
                ok = 1'b1;
                if (is_ifu) e_inst = ifu_resp_inst;
                return;
            end
            n++;
            if (n == TIMEOUT) return;
        end
    endtask

    task automatic run_instrs();
        bit ok;
        while (!m_abort) begin
            e_st = ST_FETCH;
            do m_tick(); while (!m_abort && !ifu_req_ready);
            if (m_abort) return;
            if (ifu_resp_valid) begin
                e_inst = ifu_resp_inst;
            end else begin
                e_st = ST_IWAIT;
                wait_resp(1'b1, ok);
                if (m_abort) return;
                if (!ok) begin e_st = ST_ERR; e_err = 1'b1; terminal(); return; end
            end
            e_st = ST_DECODE;
            m_tick();
            if (m_abort) return;
            if (dec_illegal) begin e_st = ST_ERR;  e_err  = 1'b1; terminal(); return; end
            if (dec_ebreak)  begin e_st = ST_HALT; e_halt = 1'b1; terminal(); return; end
            e_st = ST_EXEC;
            m_tick();
            if (m_abort) return;
            if (dec_mem) begin
                e_st = ST_MEM;
                do m_tick(); while (!m_abort && !lsu_req_ready);
                if (m_abort) return;
                if (!lsu_resp_valid) begin
                    e_st = ST_MWAIT;
                    wait_resp(1'b0, ok);
                    if (m_abort) return;
                    if (!ok) begin e_st = ST_ERR; e_err = 1'b1; terminal(); return; end
                end
            end
            e_st = ST_WB;
            m_tick();
            if (m_abort) return;
            e_cnt = e_cnt + 1'b1;
        end
    endtask

    initial begin : model
        forever begin
            e_st = ST_IDLE; e_inst = '0; e_cnt = '0; e_halt = 1'b0; e_err = 1'b0;
            m_abort = 1'b0;
            if (rst_n !== 1'b1) @(posedge rst_n);
            m_tick();
            if (!m_abort) run_instrs();
        end
    end

    initial begin : compare
        forever begin
            @(posedge clk);
            #2;
            chk("state",    64'(state),    64'(e_st));
            chk("inst_q",   64'(inst_q),   64'(e_inst));
            chk("inst_cnt", 64'(inst_cnt), 64'(e_cnt));
            chk("halt",     64'(halt),     64'(e_halt));
            chk("err",      64'(err),      64'(e_err));
            chk("ifu_req_valid", 64'(ifu_req_valid), 64'(e_st == ST_FETCH));
            chk("lsu_req_valid", 64'(lsu_req_valid), 64'(e_st == ST_MEM));
            chk("pc_we",    64'(pc_we),    64'(e_st == ST_WB));
            chk("rf_we",    64'(rf_we),    64'((e_st == ST_WB) && dec_rd_we));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_inst = '0;
        dec_mem = 1'b0; dec_rd_we = 1'b0; dec_ebreak = 1'b0; dec_illegal = 1'b0;
        lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    endtask

    // Returns at the negedge of release; DUT is in IDLE.
    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge in FETCH; returns at the negedge in DECODE.
    task automatic issue(input logic [31:0] inst, input logic mem, input logic rd_we,
                         input logic ebrk, input logic ill);
        ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; ifu_resp_inst = inst;
        dec_mem = mem; dec_rd_we = rd_we; dec_ebreak = ebrk; dec_illegal = ill;
        @(negedge clk);
        ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0;
    endtask

    initial begin : stim
        int     log_pc[$];
        int     log_rf[$];
        int     rfcnt, first_err;
        bit     seen;
        logic [1:0] lsu_seq [6];
        state_e     exp_seq [6];
        int     p_tab [4];

        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_state", 64'(state), 64'(ST_IDLE));
        chk("rst_cnt",   64'(inst_cnt), 64'd0);

        // three addi with zero-wait fetch
        ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0010_0093; dec_rd_we = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (pc_we) log_pc.push_back(j + 1);
            if (rf_we) log_rf.push_back(j + 1);
        end
        ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0;
        @(negedge clk);
        chk("addi_npc", 64'(log_pc.size()), 64'd3);
        chk("addi_nrf", 64'(log_rf.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk("addi_pc_cycle", 64'((k < log_pc.size()) ? log_pc[k] : -1), 64'(5 + 4 * k));
            chk("addi_rf_cycle", 64'((k < log_rf.size()) ? log_rf[k] : -1), 64'(5 + 4 * k));
        end
        chk("addi_cnt",   64'(inst_cnt), 64'd3);
        chk("addi_state", 64'(state), 64'(ST_FETCH));

        // lw with delayed LSU ready and response
        lsu_seq = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        exp_seq = '{ST_MEM, ST_MEM, ST_MWAIT, ST_MWAIT, ST_MWAIT, ST_WB};
        issue(32'h0000_2083, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rfcnt = 0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            {lsu_req_ready, lsu_resp_valid} = lsu_seq[s];
            chk("lw_state", 64'(state), 64'(exp_seq[s]));
            rfcnt += int'(rf_we);
        end
        @(negedge clk);
        rfcnt += int'(rf_we);
        chk("lw_rf_pulses", 64'(rfcnt), 64'd1);
        chk("lw_cnt", 64'(inst_cnt), 64'd4);

        // sw: pc update without register write
        issue(32'h0010_2023, 1'b1, 1'b0, 1'b0, 1'b0);
        lsu_req_ready = 1'b1; lsu_resp_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("sw_state", 64'(state), 64'(ST_WB));
        chk("sw_pc_we", 64'(pc_we), 64'd1);
        chk("sw_rf_we", 64'(rf_we), 64'd0);
        lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
        @(negedge clk);
        chk("sw_cnt", 64'(inst_cnt), 64'd5);

        // ebreak halts for good
        issue(INST_EBREAK, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ebreak_halt",  64'(halt), 64'd1);
        chk("ebreak_state", 64'(state), 64'(ST_HALT));
        ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1;
        seen = 1'b0;
        repeat (50) begin @(negedge clk); seen |= ifu_req_valid; end
        chk("halt_no_fetch", 64'(seen), 64'd0);
        chk("halt_cnt", 64'(inst_cnt), 64'd5);

        // illegal beats ebreak
        do_reset();
        @(negedge clk);
        issue(32'hffff_ffff, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ill_state", 64'(state), 64'(ST_ERR));
        chk("ill_err",   64'(err), 64'd1);
        chk("ill_halt",  64'(halt), 64'd0);

        // fetch timeout
        do_reset();
        @(negedge clk);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        first_err = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err && first_err < 0) first_err = k;
        end
        chk("to_cycles", 64'(first_err), 64'd16);
        chk("to_state",  64'(state), 64'(ST_ERR));

        // response in the last allowed cycle wins
        do_reset();
        @(negedge clk);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        repeat (15) @(negedge clk);
        chk("late_iwait", 64'(state), 64'(ST_IWAIT));
        ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h1234_5678;
        @(negedge clk);
        ifu_resp_valid = 1'b0;
        chk("late_state", 64'(state), 64'(ST_DECODE));
        chk("late_err",   64'(err), 64'd0);
        chk("late_inst",  64'(inst_q), 64'h1234_5678);

        // asynchronous reset in MWAIT
        do_reset();
        @(negedge clk);
        issue(32'h0000_2083, 1'b1, 1'b1, 1'b0, 1'b0);
        lsu_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        lsu_req_ready = 1'b0;
        chk("mw_state", 64'(state), 64'(ST_MWAIT));
        @(negedge clk);
        #1 rst_n = 1'b0;
        lsu_resp_valid = 1'b1;
        #1;
        chk("arst_state", 64'(state), 64'(ST_IDLE));
        chk("arst_inst",  64'(inst_q), 64'd0);
        chk("arst_strb",  64'({ifu_req_valid, lsu_req_valid, pc_we, rf_we, halt, err}), 64'd0);
        seen = 1'b0;
        @(posedge clk); #1 seen |= pc_we | rf_we;
        @(negedge clk);
        rst_n = 1'b1; lsu_resp_valid = 1'b0;
        @(negedge clk);
        seen |= pc_we | rf_we;
        chk("arst_no_wb", 64'(seen), 64'd0);
        chk("arst_fetch", 64'(state), 64'(ST_FETCH));

        // randomized episodes with varying response latency
        p_tab = '{100, 60, 20, 4};
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                ifu_req_ready  = ($urandom_range(99) < 70);
                ifu_resp_valid = ($urandom_range(99) < p_tab[ep % 4]);
                ifu_resp_inst  = $urandom;
                lsu_req_ready  = ($urandom_range(99) < 70);
                lsu_resp_valid = ($urandom_range(99) < p_tab[ep % 4]);
                dec_mem        = ($urandom_range(99) < 40);
                dec_rd_we      = 1'($urandom_range(1));
                dec_ebreak     = ($urandom_range(99) < 2);
                dec_illegal    = ($urandom_range(99) < 2);
                if ($urandom_range(299) == 0) begin
                    #1 rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
